hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline sequencing controller for the front end of the 5-stage MIPS core. It drives the PC write enable and the IF/ID register's WriteEnable/Flush, and inserts ID/EX bubbles. It detects load-use and branch-operand hazards, redirects on taken branches and jumps, and tracks the multi-cycle multiply/divide unit (MDU) so that dependent instructions wait. A saturating stall-cycle counter is provided for performance monitoring.

## Interface
- MDU_LATENCY, 4: cycles the MDU occupies EX after issue (legal range 2..15).
- CNT_W, 16: width of the stall performance counter.
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high.
- ID_Rs, ID_Rt  in  5 each  source registers of the instruction in ID.
- ID_UsesRt  in  1  ID instruction reads Rt.
- ID_Branch  in  1  ID instruction is a conditional branch (compares in ID).
- ID_BranchTaken, ID_Jump  in  1 each  redirect resolved in ID.
- ID_MduOp  in  1  ID instruction is mult/multu/div/divu.
- ID_ReadsHiLo  in  1  ID instruction is mfhi/mflo/mthi/mtlo.
- ID_Flushed  in  1  ID holds a flushed bubble (IF/ID JFlush output).
- EX_MemRead, EX_RegWrite  in  1 each; EX_Rd  in  5  destination of the instruction in EX (Rt for loads).
- MEM_MemRead  in  1; MEM_Rd  in  5  destination of the load in MEM.
- PC_WriteEnable  out  1  PC may update.
- IFID_WriteEnable  out  1  to IF/ID WriteEnable.
- IFID_Flush  out  1  to IF/ID Flush.
- IDEX_Bubble  out  1  ID/EX loads a NOP.
- MduBusy  out  1  MDU countdown active.
- StallCount  out  CNT_W  stall cycles since reset, saturating.

## Operation
- Hazard terms are combinational and evaluate to 0 when ID_Flushed=1. A register match means equal and nonzero; Rt counts only when ID_UsesRt=1.
  - LU: EX_MemRead and EX_Rd matches Rs/Rt.
  - BR_EX: ID_Branch and EX_RegWrite and EX_Rd matches.
  - BR_MEM: ID_Branch and MEM_MemRead and MEM_Rd matches.
  - MDU_HAZ: MduBusy and (ID_MduOp or ID_ReadsHiLo).
- STALL = LU | BR_EX | BR_MEM | MDU_HAZ.
- Output priority, evaluated in order:
  - Reset: PC_WriteEnable=0, IFID_WriteEnable=0, IFID_Flush=1, IDEX_Bubble=1.
  - STALL: PC_WriteEnable=0, IFID_WriteEnable=0, IFID_Flush=0, IDEX_Bubble=1. A redirect is ignored while stalled and re-evaluated next cycle.
  - Redirect (ID_BranchTaken or ID_Jump): PC_WriteEnable=1, IFID_WriteEnable=1, IFID_Flush=1, IDEX_Bubble=0.
  - Otherwise: PC_WriteEnable=1, IFID_WriteEnable=1, IFID_Flush=0, IDEX_Bubble=0.
- MDU state machine, registered: states IDLE and BUSY, with a 4-bit counter Cnt.
  - IDLE -> BUSY when ID_MduOp and not STALL and not ID_Flushed. On that edge Cnt loads MDU_LATENCY-1.
  - BUSY: Cnt decrements each cycle. At Cnt==1 the next state is IDLE.
  - In BUSY, a new MDU op is always stalled (MDU_HAZ), so no re-issue occurs while busy.
  - MduBusy = (state==BUSY).
- StallCount increments on every non-reset cycle with STALL=1. It holds at all-ones.

## Timing
- Control outputs are Mealy (same-cycle) and are sampled by the PC, IF/ID and ID/EX at the next rising edge. The state and StallCount outputs are registered.
- Reset values: state IDLE, Cnt=0, MduBusy=0, StallCount=0. Reset mid-BUSY returns to IDLE on that edge.
- Stall lengths:
  - Load-use: exactly 1 stall cycle.
  - Branch depending on an ALU result in EX: 1 cycle.
  - Branch depending on a load in EX: 2 cycles (LU, then BR_MEM).
- MDU issued at edge N: MduBusy=1 for cycles N+1..N+MDU_LATENCY-1. A dependent instruction in ID proceeds on the first cycle with MduBusy=0.
- Simultaneous events:
  - LU and a redirect: stall wins and no flush occurs.
  - ID_Flushed and a redirect: the redirect still applies.
  - MDU issue on a redirect cycle: the issue is counted (the MDU op is in ID and proceeds).
- Register $0 never causes a hazard.

## Test plan
- Reset for 2 cycles -> outputs 0/0/1/1, StallCount=0, MduBusy=0. First post-reset cycle -> 1/1/0/0.
- lw $2 in EX followed by add $3,$2,$4 in ID -> one cycle with PC_WriteEnable=0 and IDEX_Bubble=1, then normal flow. StallCount=1.
- lw $5 in EX, beq $5,$0 in ID -> two stall cycles, then the taken branch asserts IFID_Flush=1 with PC_WriteEnable=1. StallCount=2.
- mult issued, MDU_LATENCY=4, mflo in the next slot -> MduBusy high for 3 cycles and mflo stalled 3 cycles, then proceeds.
- ID_Jump=1 with ID_Flushed=1 and EX_Rd matching ID_Rs -> no stall, IFID_Flush=1.
- Reset asserted during BUSY with Cnt=2 -> next cycle MduBusy=0 and Cnt=0. Force 2^CNT_W+3 stall cycles -> StallCount holds at all-ones.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the MIPS front-end pipeline and hazard_ctrl.
// The pipeline side is the master; the hazard controller is the slave.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  // Instruction in ID
  logic [4:0]       ID_Rs;
  logic [4:0]       ID_Rt;
  logic             ID_UsesRt;
  logic             ID_Branch;
  logic             ID_BranchTaken;
  logic             ID_Jump;
  logic             ID_MduOp;
  logic             ID_ReadsHiLo;
  logic             ID_Flushed;

  // Producers further down the pipe
  logic             EX_MemRead;
  logic             EX_RegWrite;
  logic [4:0]       EX_Rd;
  logic             MEM_MemRead;
  logic [4:0]       MEM_Rd;

  // Sequencing controls and status
  logic             PC_WriteEnable;
  logic             IFID_WriteEnable;
  logic             IFID_Flush;
  logic             IDEX_Bubble;
  logic             MduBusy;
  logic [CNT_W-1:0] StallCount;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRt, ID_Branch, ID_BranchTaken, ID_Jump,
           ID_MduOp, ID_ReadsHiLo, ID_Flushed,
           EX_MemRead, EX_RegWrite, EX_Rd, MEM_MemRead, MEM_Rd,
    input  PC_WriteEnable, IFID_WriteEnable, IFID_Flush, IDEX_Bubble,
           MduBusy, StallCount
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRt, ID_Branch, ID_BranchTaken, ID_Jump,
           ID_MduOp, ID_ReadsHiLo, ID_Flushed,
           EX_MemRead, EX_RegWrite, EX_Rd, MEM_MemRead, MEM_Rd,
    output PC_WriteEnable, IFID_WriteEnable, IFID_Flush, IDEX_Bubble,
           MduBusy, StallCount
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Front-end sequencing for the 5-stage MIPS core: load-use / branch-operand
// stalls, ID redirects, MDU occupancy tracking and a saturating stall counter.
module hazard_ctrl #(
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic         Clock,
  input  logic         Reset,
  hazard_ctrl_if.slave hz
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

  localparam logic [3:0] MDU_LOAD = 4'(MDU_LATENCY - 1);

  // $0 is hard-wired to zero, so a write to it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

  mdu_state_e       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic ex_match, mem_match;
  logic lu_haz, br_ex_haz, br_mem_haz, mdu_haz;
  logic stall, redirect, mdu_issue, mdu_busy;

  assign mdu_busy = (state_q == BUSY);

  // Hazard detection
  always_comb begin
    ex_match   = reg_match(hz.EX_Rd, hz.ID_Rs) ||
                 (hz.ID_UsesRt && reg_match(hz.EX_Rd, hz.ID_Rt));
    mem_match  = reg_match(hz.MEM_Rd, hz.ID_Rs) ||
                 (hz.ID_UsesRt && reg_match(hz.MEM_Rd, hz.ID_Rt));

    // A flushed bubble in ID reads nothing, so it can never be hazarded.
    lu_haz     = !hz.ID_Flushed && hz.EX_MemRead && ex_match;
    br_ex_haz  = !hz.ID_Flushed && hz.ID_Branch && hz.EX_RegWrite && ex_match;
    br_mem_haz = !hz.ID_Flushed && hz.ID_Branch && hz.MEM_MemRead && mem_match;
    mdu_haz    = !hz.ID_Flushed && mdu_busy && (hz.ID_MduOp || hz.ID_ReadsHiLo);

    stall      = lu_haz || br_ex_haz || br_mem_haz || mdu_haz;
    redirect   = hz.ID_BranchTaken || hz.ID_Jump;
    mdu_issue  = (state_q == IDLE) && hz.ID_MduOp && !stall && !hz.ID_Flushed;
  end

  // Same-cycle pipeline controls; the stage registers sample them at the next edge.
  always_comb begin
    // NOTE: every output gets a default first so no path through this block infers a latch.
    hz.PC_WriteEnable   = 1'b1;
    hz.IFID_WriteEnable = 1'b1;
    hz.IFID_Flush       = 1'b0;
    hz.IDEX_Bubble      = 1'b0;

    if (Reset) begin
      hz.PC_WriteEnable   = 1'b0;
      hz.IFID_WriteEnable = 1'b0;
      hz.IFID_Flush       = 1'b1;
      hz.IDEX_Bubble      = 1'b1;
    end else if (stall) begin
      // A redirect under a stall is dropped; the branch is still in ID next cycle.
      hz.PC_WriteEnable   = 1'b0;
      hz.IFID_WriteEnable = 1'b0;
      hz.IDEX_Bubble      = 1'b1;
    end else if (redirect) begin
      hz.IFID_Flush       = 1'b1;
    end
  end

  // MDU occupancy countdown
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (mdu_issue) begin
          state_d = BUSY;
          cnt_d   = MDU_LOAD;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Performance counter sticks at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clock) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.MduBusy    = mdu_busy;
  assign hz.StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: stalls, redirects, MDU tracking and
// stall-counter saturation, each scenario checking its own expected values.
module tb_hazard_ctrl;

  localparam int MDU_LATENCY = 4;
  localparam int CNT_W       = 16;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(
    .MDU_LATENCY (MDU_LATENCY),
    .CNT_W       (CNT_W)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .hz    (hz)
  );

  always #5 Clock = ~Clock;

  // {PC_WriteEnable, IFID_WriteEnable, IFID_Flush, IDEX_Bubble}
  wire [3:0] ctrl = {hz.PC_WriteEnable, hz.IFID_WriteEnable, hz.IFID_Flush, hz.IDEX_Bubble};

  localparam logic [3:0] C_RESET = 4'b0011;
  localparam logic [3:0] C_STALL = 4'b0001;
  localparam logic [3:0] C_REDIR = 4'b1110;
  localparam logic [3:0] C_RUN   = 4'b1100;

  task automatic clear_inputs();
    hz.ID_Rs          = 5'd0;
    hz.ID_Rt          = 5'd0;
    hz.ID_UsesRt      = 1'b0;
    hz.ID_Branch      = 1'b0;
    hz.ID_BranchTaken = 1'b0;
    hz.ID_Jump        = 1'b0;
    hz.ID_MduOp       = 1'b0;
    hz.ID_ReadsHiLo   = 1'b0;
    hz.ID_Flushed     = 1'b0;
    hz.EX_MemRead     = 1'b0;
    hz.EX_RegWrite    = 1'b0;
    hz.EX_Rd          = 5'd0;
    hz.MEM_MemRead    = 1'b0;
    hz.MEM_Rd         = 5'd0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    Reset = 1'b1;
    tick();
    tick();
    n_vec++;
    if (ctrl !== C_RESET) begin
      n_err++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, C_RESET);
    end
    n_vec++;
    if (hz.StallCount !== '0) begin
      n_err++; $display("FAIL reset_stallcount got=%0d exp=0", hz.StallCount);
    end
    n_vec++;
    if (hz.MduBusy !== 1'b0) begin
      n_err++; $display("FAIL reset_mdubusy got=%b exp=0", hz.MduBusy);
    end
    Reset = 1'b0;
    #1;
    n_vec++;
    if (ctrl !== C_RUN) begin
      n_err++; $display("FAIL post_reset_ctrl got=%b exp=%b", ctrl, C_RUN);
    end
  endtask

  // lw $2 in EX, add $3,$2,$4 in ID
  task automatic test_load_use();
    apply_reset();
    hz.EX_MemRead = 1'b1; hz.EX_RegWrite = 1'b1; hz.EX_Rd = 5'd2;
    hz.ID_Rs = 5'd2; hz.ID_Rt = 5'd4; hz.ID_UsesRt = 1'b1;
    #1;
    n_vec++;
    if (ctrl !== C_STALL) begin
      n_err++; $display("FAIL lu_stall got=%b exp=%b", ctrl, C_STALL);
    end
    tick();
    hz.EX_MemRead = 1'b0; hz.EX_RegWrite = 1'b0; hz.EX_Rd = 5'd0;
    hz.MEM_MemRead = 1'b1; hz.MEM_Rd = 5'd2;
    #1;
    n_vec++;
    if (ctrl !== C_RUN) begin
      n_err++; $display("FAIL lu_release got=%b exp=%b", ctrl, C_RUN);
    end
    n_vec++;
    if (hz.StallCount !== 16'd1) begin
      n_err++; $display("FAIL lu_stallcount got=%0d exp=1", hz.StallCount);
    end
    // Same load, but the matching Rt is not read by the ID instruction
    clear_inputs();
    hz.EX_MemRead = 1'b1; hz.EX_Rd = 5'd4;
    hz.ID_Rs = 5'd9; hz.ID_Rt = 5'd4; hz.ID_UsesRt = 1'b0;
    #1;
    n_vec++;
    if (ctrl !== C_RUN) begin
      n_err++; $display("FAIL lu_rt_unused got=%b exp=%b", ctrl, C_RUN);
    end
    // Load targeting $0 never stalls
    hz.EX_Rd = 5'd0; hz.ID_Rs = 5'd0; hz.ID_Rt = 5'd0; hz.ID_UsesRt = 1'b1;
    #1;
    n_vec++;
    if (ctrl !== C_RUN) begin
      n_err++; $display("FAIL lu_reg_zero got=%b exp=%b", ctrl, C_RUN);
    end
  endtask

  // lw $5 in EX, beq $5,$0 in ID (taken): LU, then BR_MEM, then redirect
  task automatic test_branch_load();
    apply_reset();
    hz.EX_MemRead = 1'b1; hz.EX_RegWrite = 1'b1; hz.EX_Rd = 5'd5;
    hz.ID_Branch = 1'b1; hz.ID_BranchTaken = 1'b1;
    hz.ID_Rs = 5'd5; hz.ID_Rt = 5'd0; hz.ID_UsesRt = 1'b1;
    #1;
    n_vec++;
    if (ctrl !== C_STALL) begin
      n_err++; $display("FAIL brld_stall1 got=%b exp=%b", ctrl, C_STALL);
    end
    tick();
    hz.EX_MemRead = 1'b0; hz.EX_RegWrite = 1'b0; hz.EX_Rd = 5'd0;
    hz.MEM_MemRead = 1'b1; hz.MEM_Rd = 5'd5;
    #1;
    n_vec++;
    if (ctrl !== C_STALL) begin
      n_err++; $display("FAIL brld_stall2 got=%b exp=%b", ctrl, C_STALL);
    end
    tick();
    hz.MEM_MemRead = 1'b0; hz.MEM_Rd = 5'd0;
    #1;
    n_vec++;
    if (ctrl !== C_REDIR) begin
      n_err++; $display("FAIL brld_redirect got=%b exp=%b", ctrl, C_REDIR);
    end
    n_vec++;
    if (hz.StallCount !== 16'd2) begin
      n_err++; $display("FAIL brld_stallcount got=%0d exp=2", hz.StallCount);
    end
  endtask

  // add $7 in EX, bne $1,$7 in ID: one-cycle BR_EX stall
  task automatic test_branch_alu();
    apply_reset();
    hz.EX_RegWrite = 1'b1; hz.EX_Rd = 5'd7;
    hz.ID_Branch = 1'b1; hz.ID_Rs = 5'd1; hz.ID_Rt = 5'd7; hz.ID_UsesRt = 1'b1;
    #1;
    n_vec++;
    if (ctrl !== C_STALL) begin
      n_err++; $display("FAIL brex_stall got=%b exp=%b", ctrl, C_STALL);
    end
    tick();
    hz.EX_RegWrite = 1'b0; hz.EX_Rd = 5'd0;
    #1;
    n_vec++;
    if (ctrl !== C_RUN) begin
      n_err++; $display("FAIL brex_release got=%b exp=%b", ctrl, C_RUN);
    end
    n_vec++;
    if (hz.StallCount !== 16'd1) begin
      n_err++; $display("FAIL brex_stallcount got=%0d exp=1", hz.StallCount);
    end
    // Same producer, but ID is not a branch: ALU results are forwarded
    hz.ID_Branch = 1'b0; hz.EX_RegWrite = 1'b1; hz.EX_Rd = 5'd7;
    #1;
    n_vec++;
    if (ctrl !== C_RUN) begin
      n_err++; $display("FAIL brex_nonbranch got=%b exp=%b", ctrl, C_RUN);
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    hz.ID_Branch = 1'b1; hz.ID_BranchTaken = 1'b1; hz.ID_Rs = 5'd3;
    #1;
    n_vec++;
    if (ctrl !== C_REDIR) begin
      n_err++; $display("FAIL taken_branch got=%b exp=%b", ctrl, C_REDIR);
    end
    // Load-use plus jump: stall wins, no flush
    clear_inputs();
    hz.ID_Jump = 1'b1; hz.EX_MemRead = 1'b1; hz.EX_Rd = 5'd3; hz.ID_Rs = 5'd3;
    #1;
    n_vec++;
    if (ctrl !== C_STALL) begin
      n_err++; $display("FAIL lu_vs_jump got=%b exp=%b", ctrl, C_STALL);
    end
    // Flushed ID with a matching load: no hazard, the jump still redirects
    hz.ID_Flushed = 1'b1;
    #1;
    n_vec++;
    if (ctrl !== C_REDIR) begin
      n_err++; $display("FAIL flushed_jump got=%b exp=%b", ctrl, C_REDIR);
    end
    tick();
    n_vec++;
    if (hz.StallCount !== 16'd0) begin
      n_err++; $display("FAIL flushed_stallcount got=%0d exp=0", hz.StallCount);
    end
  endtask

  // mult issued, then mflo waits for the MDU
  task automatic test_mdu();
    apply_reset();
    hz.ID_MduOp = 1'b1;
    #1;
    n_vec++;
    if (ctrl !== C_RUN) begin
      n_err++; $display("FAIL mdu_issue_ctrl got=%b exp=%b", ctrl, C_RUN);
    end
    tick();
    hz.ID_MduOp = 1'b0; hz.ID_ReadsHiLo = 1'b1;
    for (int i = 0; i < MDU_LATENCY - 1; i++) begin
      #1;
      n_vec++;
      if (hz.MduBusy !== 1'b1) begin
        n_err++; $display("FAIL mdu_busy[%0d] got=%b exp=1", i, hz.MduBusy);
      end
      n_vec++;
      if (ctrl !== C_STALL) begin
        n_err++; $display("FAIL mflo_stall[%0d] got=%b exp=%b", i, ctrl, C_STALL);
      end
      tick();
    end
    n_vec++;
    if (hz.MduBusy !== 1'b0) begin
      n_err++; $display("FAIL mdu_done got=%b exp=0", hz.MduBusy);
    end
    n_vec++;
    if (ctrl !== C_RUN) begin
      n_err++; $display("FAIL mflo_proceed got=%b exp=%b", ctrl, C_RUN);
    end
    n_vec++;
    if (hz.StallCount !== 16'd3) begin
      n_err++; $display("FAIL mdu_stallcount got=%0d exp=3", hz.StallCount);
    end
    // Flushed MDU op does not issue
    clear_inputs();
    hz.ID_MduOp = 1'b1; hz.ID_Flushed = 1'b1;
    tick();
    n_vec++;
    if (hz.MduBusy !== 1'b0) begin
      n_err++; $display("FAIL mdu_flushed_issue got=%b exp=0", hz.MduBusy);
    end
    // MDU op on a jump cycle issues and redirects
    hz.ID_Flushed = 1'b0; hz.ID_Jump = 1'b1;
    #1;
    n_vec++;
    if (ctrl !== C_REDIR) begin
      n_err++; $display("FAIL mdu_jump_ctrl got=%b exp=%b", ctrl, C_REDIR);
    end
    tick();
    n_vec++;
    if (hz.MduBusy !== 1'b1) begin
      n_err++; $display("FAIL mdu_jump_issue got=%b exp=1", hz.MduBusy);
    end
  endtask

  // Reset arriving with Cnt=2 drops straight back to IDLE
  task automatic test_reset_busy();
    apply_reset();
    hz.ID_MduOp = 1'b1;
    tick();
    hz.ID_MduOp = 1'b0;
    tick();
    n_vec++;
    if (dut.cnt_q !== 4'd2) begin
      n_err++; $display("FAIL rstbusy_precnt got=%0d exp=2", dut.cnt_q);
    end
    Reset = 1'b1;
    #1;
    n_vec++;
    if (ctrl !== C_RESET) begin
      n_err++; $display("FAIL rstbusy_ctrl got=%b exp=%b", ctrl, C_RESET);
    end
    tick();
    n_vec++;
    if (hz.MduBusy !== 1'b0) begin
      n_err++; $display("FAIL rstbusy_mdubusy got=%b exp=0", hz.MduBusy);
    end
    n_vec++;
    if (dut.cnt_q !== 4'd0) begin
      n_err++; $display("FAIL rstbusy_cnt got=%0d exp=0", dut.cnt_q);
    end
    Reset = 1'b0;
    #1;
  endtask

  // Hold a load-use hazard for 2^CNT_W+3 cycles
  task automatic test_saturation();
    apply_reset();
    hz.EX_MemRead = 1'b1; hz.EX_Rd = 5'd1; hz.ID_Rs = 5'd1;
    for (int i = 0; i < (1 << CNT_W) - 2; i++) tick();
    n_vec++;
    if (hz.StallCount !== 16'hFFFE) begin
      n_err++; $display("FAIL sat_below got=%0d exp=65534", hz.StallCount);
    end
    for (int i = 0; i < 5; i++) tick();
    n_vec++;
    if (hz.StallCount !== 16'hFFFF) begin
      n_err++; $display("FAIL sat_hold got=%0d exp=65535", hz.StallCount);
    end
    clear_inputs();
    tick();
    n_vec++;
    if (hz.StallCount !== 16'hFFFF) begin
      n_err++; $display("FAIL sat_idle got=%0d exp=65535", hz.StallCount);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_branch_load();
    test_branch_alu();
    test_redirect();
    test_mdu();
    test_reset_busy();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
